// File: rtl/conv_pkg.sv
// Shared K=5 convolutional code definitions for the encoder framer and the Viterbi decoder.
// Generators are stored MSB = current input bit, LSB = oldest stored bit.
package conv_pkg;
  localparam int K       = 5;
  localparam int STATE_W = K - 1;
  localparam logic [K-1:0] G0 = 5'o23;
  localparam logic [K-1:0] G1 = 5'o35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_e;

  function automatic logic conv_parity(input logic [K-1:0] window, input logic [K-1:0] gen);
    conv_parity = ^(window & gen);
  endfunction
endpackage

// File: rtl/conv_shift_core.sv
// K-1 bit shift register of the convolutional encoder with combinational symbol output.
// sym[0]=c0, sym[1]=c1 for the bit presented on in_bit against the stored history.
module conv_shift_core
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       advance,
  input  logic       clear,
  output logic [1:0] sym
);

  logic [STATE_W-1:0] state_r;
  logic [K-1:0]       window_s;

  assign window_s = {in_bit, state_r};
  assign sym      = {conv_parity(window_s, G1), conv_parity(window_s, G0)};

  // shift history: newest bit enters at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= {STATE_W{1'b0}};
    end else if (clear) begin
      state_r <= {STATE_W{1'b0}};
    end else if (advance) begin
      state_r <= {in_bit, state_r[STATE_W-1:1]};
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=5 convolutional encoder with byte framing and zero-tail termination.
// Optional rate-2/3 puncturing mask enabled by defining CONV_PUNCT_EN.
module conv_encoder_framer
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_last,
  output logic [1:0] sym_mask
);

  localparam int TAIL_W = 3;
  localparam logic [TAIL_W-1:0] TAIL_LEN = TAIL_W'(STATE_W);

  fsm_e              state_r, state_s;
  logic [7:0]        byte_r, byte_s;
  logic              last_r, last_s;
  logic [2:0]        bits_left_r, bits_left_s;
  logic [2:0]        bit_idx_s;
  logic [TAIL_W-1:0] tail_cnt_r, tail_cnt_s;
  logic [1:0]        sym_out_r, sym_out_s;
  logic              sym_valid_r, sym_valid_s;
  logic              sym_last_r, sym_last_s;
  logic              free_s, load_s, in_ready_s;
  logic              core_bit_s, core_clr_s;
  logic [1:0]        core_sym_s;

  conv_shift_core u_core (
    .clk     (clk),
    .rst     (rst),
    .in_bit  (core_bit_s),
    .advance (load_s),
    .clear   (core_clr_s),
    .sym     (core_sym_s)
  );

  assign free_s    = ~sym_valid_r | sym_ready;
  assign bit_idx_s = bits_left_r - 3'd1;

  // next-state, byte buffer and symbol load decisions
  always_comb begin
    state_s     = state_r;
    byte_s      = byte_r;
    last_s      = last_r;
    bits_left_s = bits_left_r;
    tail_cnt_s  = tail_cnt_r;
    sym_out_s   = sym_out_r;
    sym_valid_s = sym_valid_r;
    sym_last_s  = sym_last_r;
    core_bit_s  = 1'b0;
    core_clr_s  = 1'b0;
    load_s      = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          byte_s      = in_data;
          last_s      = in_last;
          bits_left_s = 3'd7;
          core_bit_s  = in_data[7];
          load_s      = 1'b1;
          state_s     = DATA;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (!free_s) begin
          state_s = DATA;
        end else if (bits_left_r != 3'd0) begin
          core_bit_s  = byte_r[bit_idx_s];
          bits_left_s = bit_idx_s;
          load_s      = 1'b1;
        end else if (last_r) begin
          core_bit_s = 1'b0;
          tail_cnt_s = {{(TAIL_W-1){1'b0}}, 1'b1};
          load_s     = 1'b1;
          state_s    = TAIL;
        end else begin
          // byte exhausted mid-frame: take the next byte without a bubble
          in_ready_s = 1'b1;
          if (in_valid) begin
            byte_s      = in_data;
            last_s      = in_last;
            bits_left_s = 3'd7;
            core_bit_s  = in_data[7];
            load_s      = 1'b1;
          end else begin
            sym_valid_s = 1'b0;
          end
        end
      end
      TAIL: begin
        if (!free_s) begin
          state_s = TAIL;
        end else if (tail_cnt_r == TAIL_LEN) begin
          sym_valid_s = 1'b0;
          sym_last_s  = 1'b0;
          core_clr_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          core_bit_s = 1'b0;
          tail_cnt_s = tail_cnt_r + {{(TAIL_W-1){1'b0}}, 1'b1};
          load_s     = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (load_s) begin
      sym_out_s   = core_sym_s;
      sym_valid_s = 1'b1;
      sym_last_s  = (state_s == TAIL) && (tail_cnt_s == TAIL_LEN);
    end else begin
      sym_out_s = sym_out_s;
    end
  end

  // FSM, byte buffer and registered symbol outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      byte_r      <= 8'h00;
      last_r      <= 1'b0;
      bits_left_r <= 3'd0;
      tail_cnt_r  <= {TAIL_W{1'b0}};
      sym_out_r   <= 2'b00;
      sym_valid_r <= 1'b0;
      sym_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      byte_r      <= byte_s;
      last_r      <= last_s;
      bits_left_r <= bits_left_s;
      tail_cnt_r  <= tail_cnt_s;
      sym_out_r   <= sym_out_s;
      sym_valid_r <= sym_valid_s;
      sym_last_r  <= sym_last_s;
    end
  end

  assign in_ready  = in_ready_s & ~rst;
  assign sym_out   = sym_out_r;
  assign sym_valid = sym_valid_r;
  assign sym_last  = sym_last_r;

`ifdef CONV_PUNCT_EN
  logic       par_r;
  logic       par_cur_s;
  logic [1:0] sym_mask_r;

  // frame bit index parity restarts with the first bit of every frame
  assign par_cur_s = (state_r == IDLE) ? 1'b0 : par_r;

  // puncturing mask follows each loaded symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      par_r      <= 1'b0;
      sym_mask_r <= 2'b11;
    end else if (load_s) begin
      par_r      <= ~par_cur_s;
      sym_mask_r <= par_cur_s ? 2'b01 : 2'b11;
    end else begin
      par_r      <= par_r;
      sym_mask_r <= sym_mask_r;
    end
  end

  assign sym_mask = sym_mask_r;
`else
  assign sym_mask = 2'b11;
`endif

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer: bit-level reference encoder, symbol scoreboard
// and hand-computed impulse/stream literals.
module tb_conv_encoder_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready = 1'b1;
  logic       sym_last;
  logic [1:0] sym_mask;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  int gap_cnt = 0;
  logic frame_on = 1'b0;
  logic hold_pending = 1'b0;
  logic [4:0] held;
  logic [4:0] exp_q[$];
  logic [4:0] mdl_q[$];
  logic [1:0] cap_q[$];
  logic [1:0] capm_q[$];

  // sym_out = {c1, c0}
  logic [1:0] imp_lit[12] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] stream_lit[5] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b01};

  conv_encoder_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_last  (sym_last),
    .sym_mask  (sym_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // reference encoder straight from the code definition: taps by bit age
  task automatic build_model(input logic [7:0] b0, input logic [7:0] b1, input int nbytes);
    logic bits[$];
    logic hist[4];
    logic [4:0] g0, g1;
    logic b, c0, c1, lst;
    logic [1:0] msk;
    g0 = 5'o23;
    g1 = 5'o35;
    mdl_q.delete();
    for (int a = 0; a < 4; a++) hist[a] = 1'b0;
    for (int j = 7; j >= 0; j--) bits.push_back(b0[j]);
    if (nbytes > 1) for (int j = 7; j >= 0; j--) bits.push_back(b1[j]);
    for (int t = 0; t < 4; t++) bits.push_back(1'b0);
    for (int n = 0; n < bits.size(); n++) begin
      b  = bits[n];
      c0 = b & g0[4];
      c1 = b & g1[4];
      for (int a = 1; a < 5; a++) begin
        c0 = c0 ^ (hist[a-1] & g0[4-a]);
        c1 = c1 ^ (hist[a-1] & g1[4-a]);
      end
      for (int a = 3; a > 0; a--) hist[a] = hist[a-1];
      hist[0] = b;
      lst = (n == bits.size() - 1);
`ifdef CONV_PUNCT_EN
      msk = (n % 2 == 1) ? 2'b01 : 2'b11;
`else
      msk = 2'b11;
`endif
      mdl_q.push_back({c1, c0, lst, msk});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic lst);
    int n;
    logic hs;
    logic done;
    n = 0;
    done = 1'b0;
    in_data = d;
    in_last = lst;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
      if (hs) done = 1'b1;
      else if (n > 200) begin
        chk("accept_timeout", 32'(n), 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("frame_drain", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    chk("idle_state", 32'({in_ready, sym_valid, sym_last}), 32'({1'b1, 1'b0, 1'b0}));
  endtask

  task automatic check_impulse_capture(input string nm);
    chk({nm, "_len"}, 32'(cap_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < cap_q.size(); i++) chk(nm, 32'(cap_q[i]), 32'(imp_lit[i]));
  endtask

  // sym_ready driver: steady high or the 1,0,0,1 pattern
  initial begin
    int cyc;
    logic [3:0] pat;
    cyc = 0;
    pat = 4'b1001;
    forever begin
      tick();
      sym_ready = (rdy_mode == 0) ? 1'b1 : pat[3 - (cyc % 4)];
      cyc++;
    end
  end

  // scoreboard: every handshake against the model, stalls must hold outputs
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      hold_pending = 1'b0;
      frame_on = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("stall_hold", 32'({sym_valid, sym_out, sym_last, sym_mask}), 32'({1'b1, held}));
        hold_pending = 1'b0;
      end
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sym: got %0h expected none", sym_out);
        end else begin
          e = exp_q.pop_front();
          chk("sym", 32'({sym_out, sym_last, sym_mask}), 32'(e));
        end
        cap_q.push_back(sym_out);
        capm_q.push_back(sym_mask);
        frame_on = !sym_last;
      end else if (sym_valid) begin
        hold_pending = 1'b1;
        held = {sym_out, sym_last, sym_mask};
      end else if (frame_on) begin
        gap_cnt++;
      end
    end
  end

  initial begin
    int n;
    // reset with a pending byte
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", 32'({in_ready, sym_valid, sym_out, sym_last, sym_mask}),
        32'({1'b0, 1'b0, 2'b00, 1'b0, 2'b11}));
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("reset_no_handshake", 32'({sym_valid, in_ready}), 32'({1'b0, 1'b1}));

    // pin the reference model against hand-derived sequences
    build_model(8'h80, 8'h00, 1);
    chk("model_imp_len", 32'(mdl_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk("model_imp", 32'(mdl_q[i][4:3]), 32'(imp_lit[i]));
    build_model(8'hFF, 8'h00, 2);
    chk("model_stream_len", 32'(mdl_q.size()), 32'd20);
    for (int i = 0; i < 5; i++) chk("model_stream", 32'(mdl_q[i][4:3]), 32'(stream_lit[i]));

    // impulse
    build_model(8'h80, 8'h00, 1);
    exp_q = mdl_q;
    cap_q.delete();
    capm_q.delete();
    send_byte(8'h80, 1'b1);
    chk("first_latency", 32'({sym_valid, sym_out}), 32'({1'b1, 2'b11}));
    finish_frame();
    check_impulse_capture("impulse");
    for (int i = 0; i < 12 && i < capm_q.size(); i++) begin
`ifdef CONV_PUNCT_EN
      chk("punct_mask", 32'(capm_q[i]), (i % 2 == 1) ? 32'h1 : 32'h3);
`else
      chk("mask", 32'(capm_q[i]), 32'h3);
`endif
    end

    // streaming two bytes
    build_model(8'hFF, 8'h00, 2);
    exp_q = mdl_q;
    cap_q.delete();
    gap_cnt = 0;
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b1);
    finish_frame();
    chk("stream_len", 32'(cap_q.size()), 32'd20);
    chk("stream_gaps", 32'(gap_cnt), 32'd0);
    for (int i = 0; i < 5 && i < cap_q.size(); i++) chk("stream_head", 32'(cap_q[i]), 32'(stream_lit[i]));

    // backpressure
    rdy_mode = 1;
    build_model(8'h80, 8'h00, 1);
    exp_q = mdl_q;
    cap_q.delete();
    send_byte(8'h80, 1'b1);
    finish_frame();
    check_impulse_capture("backpressure");
    rdy_mode = 0;
    tick();

    // reset during symbol 4 of an 0xFF frame
    build_model(8'hFF, 8'h00, 1);
    exp_q = mdl_q;
    cap_q.delete();
    send_byte(8'hFF, 1'b1);
    n = 0;
    while (cap_q.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_reach", 32'(cap_q.size()), 32'd3);
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    chk("midrst_cleared", 32'({sym_valid, sym_last}), 32'd0);
    build_model(8'h80, 8'h00, 1);
    exp_q = mdl_q;
    cap_q.delete();
    send_byte(8'h80, 1'b1);
    finish_frame();
    check_impulse_capture("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
